// File: rtl/roba_mul_pipe.sv
// roba_mul_pipe: 3-stage signed multiplier with per-beat exact or RoBA approximate product.
module roba_mul_pipe #(
  parameter int W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       A,
  input  logic [W-1:0]       B,
  input  logic               exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     P,
  output logic               P_exact,
  output logic [CNT_W-1:0]   op_count
);
  localparam int IW = $clog2(W + 1);
  localparam int TW = 2 * W + 1;
  // Shift index of the nearest power of two: MSB position, bumped when the next bit is set.
  function automatic logic [IW-1:0] rnd(input logic [W-1:0] m);
    rnd = '0;
    for (int i = 1; i < W; i++)
      if (m[i]) rnd = IW'(i) + IW'(m[i-1]);
  endfunction
  logic           en;
  logic [W-1:0]   am, bm;
  logic           v1, s1_s, s1_ex, s1_za, s1_zb;
  logic [W-1:0]   s1_am, s1_bm;
  logic [IW-1:0]  s1_ra, s1_rb;
  logic           v2, s2_s, s2_ex;
  logic [TW-1:0]  t1, t2, t3, t1_c, t2_c, t3_c, mag;
  assign en = out_ready | ~out_valid;
  assign in_ready = en;
  assign am = A[W-1] ? -A : A;
  assign bm = B[W-1] ? -B : B;
  always_comb begin
    t1_c = s1_ex ? TW'(s1_am) * TW'(s1_bm) : (s1_za ? '0 : TW'(s1_bm) << s1_ra);
    t2_c = (s1_ex | s1_zb) ? '0 : TW'(s1_am) << s1_rb;
    t3_c = (s1_ex | s1_za | s1_zb) ? '0 : TW'(1) << ((IW+1)'(s1_ra) + (IW+1)'(s1_rb));
    mag = t1 + t2 - t3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      P <= '0;
      P_exact <= 1'b0;
      op_count <= '0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        s1_am <= am;
        s1_bm <= bm;
        s1_s <= A[W-1] ^ B[W-1];
        s1_ex <= exact;
        s1_ra <= rnd(am);
        s1_rb <= rnd(bm);
        s1_za <= am == '0;
        s1_zb <= bm == '0;
        v2 <= v1;
        s2_s <= s1_s;
        s2_ex <= s1_ex;
        t1 <= t1_c;
        t2 <= t2_c;
        t3 <= t3_c;
        out_valid <= v2;
        if (v2) begin
          P <= (s2_s && mag != '0) ? -mag[2*W-1:0] : mag[2*W-1:0];
          P_exact <= s2_ex;
        end
      end
      if (out_valid && out_ready && op_count != '1) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_roba_mul_pipe.sv
// tb_roba_mul_pipe: directed W=8 scenarios and randomized W=32 scoreboard run.
module tb_roba_mul_pipe;
  logic clk = 0, rst = 1, in_valid = 0, exact = 0, out_ready = 1;
  logic [7:0] A8 = 0, B8 = 0;
  logic [31:0] A32 = 0, B32 = 0;
  logic rdy8, rdy32, v8, v32, pe8, pe32;
  logic [15:0] P8;
  logic [63:0] P32;
  logic [2:0] cnt8;
  logic [15:0] cnt32;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  roba_mul_pipe #(.W(8), .CNT_W(3)) d8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .A(A8), .B(B8), .exact(exact), .out_valid(v8), .out_ready(out_ready), .P(P8), .P_exact(pe8), .op_count(cnt8));
  roba_mul_pipe #(.W(32)) d32 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .A(A32), .B(B32), .exact(exact), .out_valid(v32), .out_ready(out_ready), .P(P32), .P_exact(pe32), .op_count(cnt32));

  function automatic logic [127:0] rpow(input logic [127:0] m);
    int p = -1;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    if (p < 0) return 128'd0;
    if (p >= 1 && m[p-1]) return 128'd1 << (p + 1);
    return 128'd1 << p;
  endfunction

  function automatic logic [127:0] ref_p(input longint a, input longint b, input logic ex, input int w);
    logic [127:0] am, bm, ar, br, mg;
    am = a < 0 ? 128'(-a) : 128'(a);
    bm = b < 0 ? 128'(-b) : 128'(b);
    ar = rpow(am);
    br = rpow(bm);
    mg = ex ? am * bm : ar * bm + br * am - ar * br;
    if ((a < 0) != (b < 0)) mg = -mg;
    return mg & ((128'd1 << (2 * w)) - 1);
  endfunction

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", v8); end
    checks++; if (P8 !== 16'd0) begin errors++; $display("FAIL reset_P got %h want 0", P8); end
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL reset_P_exact got %b want 0", pe8); end
    checks++; if (cnt8 !== 3'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", cnt8); end
    checks++; if (v32 !== 1'b0 || cnt32 !== 16'd0) begin errors++; $display("FAIL reset_w32 got v=%b cnt=%0d want 0 0", v32, cnt32); end
    rst = 0;
    checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", rdy8); end
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic ex, input logic [15:0] exp, input string nm);
    int lat;
    A8 = a; B8 = b; exact = ex; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!v8 && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL %s_latency got %0d want 3", nm, lat); end
    checks++; if (P8 !== exp || pe8 !== ex) begin errors++; $display("FAIL %s got P=%h tag=%b want P=%h tag=%b", nm, P8, pe8, exp, ex); end
    @(posedge clk); #1;
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL %s_single got out_valid=%b want 0", nm, v8); end
  endtask

  task automatic test_directed();
    run_one(8'd6, 8'd5, 1'b0, 16'd32, "approx_6x5");
    run_one(8'd6, 8'd5, 1'b1, 16'd30, "exact_6x5");
    run_one(8'hFA, 8'd5, 1'b0, 16'hFFE0, "approx_m6x5");
    run_one(8'd3, 8'd3, 1'b0, 16'd8, "approx_3x3");
    run_one(8'd7, 8'd7, 1'b0, 16'd48, "approx_7x7");
    run_one(8'd0, 8'hB3, 1'b0, 16'd0, "approx_0xm77");
    run_one(8'd0, 8'hB3, 1'b1, 16'd0, "exact_0xm77");
    run_one(8'h80, 8'h80, 1'b0, 16'd16384, "approx_min");
    run_one(8'h80, 8'h80, 1'b1, 16'd16384, "exact_min");
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] held = 0;
    logic stalled = 0;
    logic [7:0] ba[5], bb[5];
    logic be[5];
    int sent = 0, got = 0;
    for (int i = 0; i < 5; i++) begin ba[i] = 8'($urandom); bb[i] = 8'($urandom); be[i] = 1'($urandom); end
    rst = 1; @(posedge clk); #1; rst = 0;
    for (int c = 1; c <= 20; c++) begin
      in_valid = sent < 5;
      if (sent < 5) begin A8 = ba[sent]; B8 = bb[sent]; exact = be[sent]; end
      out_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (stalled) begin
        checks++; if (v8 !== 1'b1 || P8 !== held) begin errors++; $display("FAIL b2b_hold got v=%b P=%h want v=1 P=%h", v8, P8, held); end
      end
      if (v8 && !out_ready) begin
        checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_stall got %b want 0", rdy8); end
      end
      if (v8 && out_ready) begin
        got++;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra got P=%h want no result", P8); end
        else begin
          e = q.pop_front();
          if ({pe8, P8} !== e) begin errors++; $display("FAIL b2b_result got %h want %h", {pe8, P8}, e); end
        end
      end
      stalled = v8 && !out_ready;
      held = P8;
      if (in_valid && rdy8) begin
        q.push_back({exact, 16'(ref_p(longint'($signed(A8)), longint'($signed(B8)), exact, 8))});
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got !== 5 || q.size() !== 0) begin errors++; $display("FAIL b2b_count got %0d results want 5", got); end
    checks++; if (cnt8 !== 3'd5) begin errors++; $display("FAIL b2b_op_count got %0d want 5", cnt8); end
  endtask

  task automatic test_saturation();
    in_valid = 1; out_ready = 1; A8 = 8'd1; B8 = 8'd1; exact = 1;
    repeat (4) @(posedge clk);
    #1; in_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (cnt8 !== 3'd7) begin errors++; $display("FAIL sat_op_count got %0d want 7", cnt8); end
  endtask

  task automatic test_reset_flush();
    in_valid = 1; out_ready = 1; A8 = 8'd11; B8 = 8'd13; exact = 0;
    repeat (2) @(posedge clk);
    #1; in_valid = 0; rst = 1;
    @(posedge clk); #1; rst = 0;
    checks++; if (v8 !== 1'b0 || cnt8 !== 3'd0) begin errors++; $display("FAIL flush_reset got v=%b cnt=%0d want 0 0", v8, cnt8); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL flush_stray got out_valid=%b want 0", v8); end
    end
    run_one(8'd9, 8'd10, 1'b0, 16'(ref_p(9, 10, 1'b0, 8)), "flush_next");
  endtask

  task automatic test_random();
    logic [64:0] q[$];
    logic [64:0] e;
    logic [63:0] held = 0;
    logic stalled = 0;
    int n = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (stalled) begin
        checks++; if (v32 !== 1'b1 || P32 !== held) begin errors++; $display("FAIL rand_hold got v=%b P=%h want v=1 P=%h", v32, P32, held); end
      end
      if (v32 && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_extra got P=%h want no result", P32); end
        else begin
          e = q.pop_front();
          n++;
          if ({pe32, P32} !== e) begin errors++; $display("FAIL rand_result got %h want %h", {pe32, P32}, e); end
        end
      end
      stalled = v32 && !out_ready;
      held = P32;
      if (in_valid && rdy32)
        q.push_back({exact, 64'(ref_p(longint'($signed(A32)), longint'($signed(B32)), exact, 32))});
      @(posedge clk); #1;
      if (c < 380) begin
        in_valid = $urandom_range(3) != 0;
        A32 = $urandom_range(7) == 0 ? 32'h80000000 : ($urandom_range(7) == 0 ? 32'd0 : $urandom);
        B32 = $urandom_range(7) == 0 ? 32'h80000000 : $urandom;
        exact = 1'($urandom);
        out_ready = $urandom_range(3) != 0;
      end else begin
        in_valid = 0; out_ready = 1;
      end
    end
    checks++; if (q.size() !== 0 || n < 50) begin errors++; $display("FAIL rand_drain got %0d left %0d done want 0 left", q.size(), n); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_saturation();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/roba_mul_pipe.md
ROBA_MUL_PIPE -- requirements
Module: roba_mul_pipe

Interface
REQ-001 Parameter W, default 32, operand width in bits (two's complement); legal range 4..64.
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 A  input  W  signed multiplicand.
REQ-008 B  input  W  signed multiplier.
REQ-009 exact  input  1  per-beat mode: 1 = exact product, 0 = RoBA approximate product.
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 P  output  2W  signed product.
REQ-013 P_exact  output  1  mode tag travelling with P.
REQ-014 op_count  output  CNT_W  number of result beats accepted downstream, saturating.

Function
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1; A, B and exact SHALL be captured together.
REQ-016 The block SHALL be a 3-stage pipeline: S1 sign/magnitude and rounding; S2 shifted partial terms; S3 add/subtract, sign restore and output register.
REQ-017 Pipeline enable en = out_ready OR NOT out_valid; in_ready SHALL equal en, and all stages SHALL advance only when en = 1.
REQ-018 Latency SHALL be exactly 3 cycles from acceptance to out_valid when no stall occurs; throughput SHALL be 1 beat/cycle.
REQ-019 Bubbles SHALL propagate as invalid stages and are not compacted; per-stage valid bits SHALL be carried alongside the data.
REQ-020 While out_valid = 1 and out_ready = 0, P, P_exact and out_valid SHALL hold stable.
REQ-021 S1 SHALL form magnitudes |A| and |B| in W bits (|-2^(W-1)| = 2^(W-1), unsigned) and the result sign s = sign(A) XOR sign(B).
REQ-022 Rounding: for magnitude m > 0 with MSB index p, R(m) = 2^(p+1) if p >= 1 and bit p-1 of m is 1, else 2^p; R(0) = 0; R SHALL be held as a shift index plus a zero flag.
REQ-023 Approximate magnitude SHALL be Ar*|B| + Br*|A| - Ar*Br, with Ar = R(|A|) and Br = R(|B|), formed only by shifts, one addition and one subtraction in at least 2W+1 bits.
REQ-024 Exact magnitude SHALL be |A|*|B|.
REQ-025 P SHALL equal the negated magnitude when s = 1 and the magnitude is nonzero, else the magnitude; a zero operand SHALL yield P = 0 in both modes.
REQ-026 The approximate result SHALL always fit in 2W signed bits; no saturation logic is required.
REQ-027 op_count SHALL increment by 1 on each cycle with out_valid AND out_ready, and SHALL stick at 2^CNT_W - 1.

Reset
REQ-028 While rst = 1 at a clock edge: all stage valids, out_valid, P, P_exact and op_count SHALL become 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset asserted mid-operation SHALL discard every in-flight beat; no result from a beat accepted before reset SHALL appear afterwards.

Verification
REQ-031 W=8, A=6, B=5, exact=0, out_ready=1 -> three cycles later P=32 (Ar=8, Br=4), P_exact=0; the same beat with exact=1 -> P=30.
REQ-032 W=8, A=-6, B=5, approximate -> P=-32; A=3, B=3 -> P=8; A=7, B=7 -> P=48; A=0, B=-77 -> P=0.
REQ-033 W=8, A=-128, B=-128, exact=0 and exact=1 -> P=16384 in both modes; no overflow.
REQ-034 Back-to-back beats on 5 consecutive cycles with out_ready low for cycles 4-6 -> in_ready low while stalled, P held stable, all 5 results emitted in order with none lost or duplicated; op_count=5.
REQ-035 Assert rst for 1 cycle while 2 beats are in flight -> out_valid=0 and op_count=0 next cycle; the next accepted beat emerges after exactly 3 cycles.
REQ-036 W=32 random signed operands, mixed modes and random out_ready -> exact-mode P matches the reference A*B; approximate-mode P matches the REQ-022/REQ-023 model bit for bit.
